// File: rtl/uk101_pkg.sv
// Shared types and the write-side line-ending translation used by the ASCII feeder.
package uk101_pkg;
  typedef enum logic [1:0] {EOL_PASS, EOL_LF2CR, EOL_DROP_LF, EOL_DROP_CR} eol_mode_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {FD_IDLE, FD_PRESENT, FD_GAP} feeder_state_t;

  // Returns {keep, byte}; keep=0 means the byte is discarded before the FIFO.
  function automatic logic [8:0] eol_xlate(input eol_mode_t mode, input logic [7:0] b);
    logic [8:0] r;
    r = {1'b1, b};
    case (mode)
      EOL_LF2CR:   if (b == ASCII_LF) r = {1'b1, ASCII_CR};
      EOL_DROP_LF: if (b == ASCII_LF) r[8] = 1'b0;
      EOL_DROP_CR: if (b == ASCII_CR) r[8] = 1'b0;
      default: ;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/ioctl_ascii_feeder_if.sv
// hps_io download side plus the paced valid/ready byte port of the ASCII feeder.
interface ioctl_ascii_feeder_if;
  logic       ioctl_download;
  logic       ioctl_wr;
  logic [7:0] ioctl_index;
  logic [7:0] ioctl_dout;
  logic       ioctl_wait;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_dout, out_ready,
    input  ioctl_wait, out_data, out_valid
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_dout, out_ready,
    output ioctl_wait, out_data, out_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through dout; a push while full only lands
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/ioctl_ascii_feeder.sv
// Buffers hps_io download bytes, translates line endings on write and paces them out
// with per-character and end-of-line gaps.
module ioctl_ascii_feeder
  import uk101_pkg::*;
#(
  parameter int         DEPTH       = 64,
  parameter int         DLY_W       = 20,
  parameter int         WAIT_MARGIN = 2,
  parameter logic [7:0] INDEX       = 8'd0
) (
  input  logic                clk_sys,
  input  logic                reset,
  ioctl_ascii_feeder_if.slave bus,
  input  logic [1:0]          eol_mode,
  input  logic [DLY_W-1:0]    char_delay,
  input  logic [DLY_W-1:0]    line_delay,
  output logic                busy,
  output logic                overflow
);
  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_THR = CW'(DEPTH - WAIT_MARGIN);

  feeder_state_t    state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             wait_q, wait_d, busy_q, busy_d, ovf_q, ovf_d, dl_q;

  logic       slot_ok, wr_acc, push, pop, full, empty;
  logic [8:0] xl;
  logic [7:0] fifo_dout;
  logic [CW-1:0] fifo_count;

  assign slot_ok = (bus.ioctl_index == INDEX);
  assign wr_acc  = bus.ioctl_download & bus.ioctl_wr & slot_ok;
  assign xl      = eol_xlate(eol_mode_t'(eol_mode), bus.ioctl_dout);
  assign push    = wr_acc & xl[8];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (xl[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      FD_IDLE: if (!empty) begin
        pop     = 1'b1;
        data_d  = fifo_dout;
        state_d = FD_PRESENT;
      end
      FD_PRESENT: if (bus.out_ready) begin
        cnt_d   = (data_q == ASCII_CR) ? line_delay : char_delay;
        state_d = FD_GAP;
      end
      FD_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (!empty) begin
          pop     = 1'b1;
          data_d  = fifo_dout;
          state_d = FD_PRESENT;
        end else state_d = FD_IDLE;
      end
      default: state_d = FD_IDLE;
    endcase
  end

  // A new download on our slot clears the sticky loss flag; a loss in that same cycle still wins.
  always_comb begin
    wait_d = (fifo_count >= WAIT_THR);
    busy_d = (bus.ioctl_download & slot_ok) | ~empty | (state_q != FD_IDLE);
    ovf_d  = ovf_q;
    if (bus.ioctl_download & slot_ok & ~dl_q) ovf_d = 1'b0;
    if (push & full & ~pop)                  ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= FD_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      dl_q    <= bus.ioctl_download;
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = (state_q == FD_PRESENT);
  assign busy           = busy_q;
  assign overflow       = ovf_q;
endmodule
